radio_rx_multi: RTL

Multi-channel RC-receiver PWM decoder for the quad controller: measures the high-time of up to NCH independent radio servo lines in EN ticks and rejects pulses that are out of range. Each channel tracks its own link status and substitutes a failsafe width when it goes offline. It generalises the single-channel receiver with a per-channel glitch filter length, range validation, update/reject strobes, failsafe substitution and an aggregate online flag. It sits between the board radio pins and the flight-control register file.

---
 rtl/radio_pkg.sv | 26 ++
 rtl/radio_rx_ch.sv | 134 +++++++++++++
 rtl/radio_rx_multi.sv | 61 ++++++
 3 files changed

// File: rtl/radio_pkg.sv
// Shared constants, channel indices and the pulse validation helper for the
// radio receiver blocks.
package radio_pkg;

    localparam int unsigned NCH_DEF      = 6;
    localparam int unsigned PW_BITS_DEF  = 12;
    localparam int unsigned TO_BITS_DEF  = 15;
    localparam int unsigned FILT_DEF     = 4;
    localparam int unsigned PW_MIN_DEF   = 800;
    localparam int unsigned PW_MAX_DEF   = 2200;
    localparam int unsigned FAILSAFE_DEF = 1500;

    localparam int unsigned CH_ROLL  = 0;
    localparam int unsigned CH_PITCH = 1;
    localparam int unsigned CH_THR   = 2;
    localparam int unsigned CH_YAW   = 3;
    localparam int unsigned CH_AUX0  = 4;
    localparam int unsigned CH_AUX1  = 5;

    // A saturated count means the line was stuck high, never a real pulse.
    function automatic logic width_ok(input int unsigned cnt, input int unsigned lo,
                                      input int unsigned hi, input int unsigned sat);
        return (cnt >= lo) && (cnt <= hi) && (cnt != sat);
    endfunction

endpackage

// File: rtl/radio_rx_ch.sv
// One radio channel: synchroniser, glitch filter, edge detect, width counter,
// range validation and link timeout with failsafe substitution.
module radio_rx_ch
    import radio_pkg::*;
#(
    parameter int unsigned PW_BITS  = PW_BITS_DEF,
    parameter int unsigned TO_BITS  = TO_BITS_DEF,
    parameter int unsigned FILT     = FILT_DEF,
    parameter int unsigned PW_MIN   = PW_MIN_DEF,
    parameter int unsigned PW_MAX   = PW_MAX_DEF,
    parameter int unsigned FAILSAFE = FAILSAFE_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               radio_i,
    output logic [PW_BITS-1:0] pulse_width_o,
    output logic               new_pulse_o,
    output logic               reject_o,
    output logic               online_o
);

    localparam logic [3:0]         RunLast = 4'(FILT - 1);
    localparam int unsigned        PwSat   = (32'd1 << PW_BITS) - 1;
    localparam logic [TO_BITS-1:0] ToLast  = {{(TO_BITS-1){1'b1}}, 1'b0};

    logic [1:0]         sync_q, sync_d;
    logic               clean_q, clean_d;
    logic               clean_dly_q, clean_dly_d;
    logic [3:0]         run_q, run_d;
    logic [PW_BITS-1:0] cnt_q, cnt_d;
    logic [PW_BITS-1:0] cap_q, cap_d;
    logic               pend_q, pend_d;
    logic [TO_BITS-1:0] to_q, to_d;
    logic [PW_BITS-1:0] pw_q, pw_d;
    logic               new_q, new_d;
    logic               rej_q, rej_d;
    logic               online_q, online_d;
    logic               rise, fall, accept, timeout;

    always_comb begin
        sync_d      = {sync_q[0], radio_i};
        clean_d     = clean_q;
        run_d       = run_q;
        clean_dly_d = clean_q;
        if (en_i) begin
            if (sync_q[1] != clean_q) begin
                if (run_q == RunLast) begin
                    clean_d = ~clean_q;
                    run_d   = '0;
                end else begin
                    run_d = run_q + 4'd1;
                end
            end else begin
                run_d = '0;
            end
        end

        rise = clean_q & ~clean_dly_q;
        fall = ~clean_q & clean_dly_q;

        // The rise cycle itself is high time, so restart at 1 rather than 0.
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = en_i ? PW_BITS'(1) : '0;
        end else if (fall) begin
            cnt_d = '0;
        end else if (en_i && clean_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        pend_d = fall;
        cap_d  = fall ? cnt_q : cap_q;

        accept = pend_q & width_ok(32'(cap_q), PW_MIN, PW_MAX, PwSat);
        new_d  = accept;
        rej_d  = pend_q & ~accept;

        to_d    = to_q;
        timeout = 1'b0;
        if (accept) begin
            to_d = '0;
        end else if (en_i && (to_q != '1)) begin
            to_d    = to_q + 1'b1;
            timeout = (to_q == ToLast);
        end

        pw_d     = pw_q;
        online_d = online_q;
        if (accept) begin
            pw_d     = cap_q;
            online_d = 1'b1;
        end else if (timeout) begin
            pw_d     = PW_BITS'(FAILSAFE);
            online_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q      <= '0;
            clean_q     <= 1'b0;
            clean_dly_q <= 1'b0;
            run_q       <= '0;
            cnt_q       <= '0;
            cap_q       <= '0;
            pend_q      <= 1'b0;
            to_q        <= '0;
            pw_q        <= PW_BITS'(FAILSAFE);
            new_q       <= 1'b0;
            rej_q       <= 1'b0;
            online_q    <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            clean_q     <= clean_d;
            clean_dly_q <= clean_dly_d;
            run_q       <= run_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            pend_q      <= pend_d;
            to_q        <= to_d;
            pw_q        <= pw_d;
            new_q       <= new_d;
            rej_q       <= rej_d;
            online_q    <= online_d;
        end
    end

    assign pulse_width_o = pw_q;
    assign new_pulse_o   = new_q;
    assign reject_o      = rej_q;
    assign online_o      = online_q;

endmodule

// File: rtl/radio_rx_multi.sv
// Multi-channel RC receiver: NCH independent pulse decoders plus a registered
// aggregate link-alive flag.
module radio_rx_multi
    import radio_pkg::*;
#(
    parameter int unsigned NCH      = NCH_DEF,
    parameter int unsigned PW_BITS  = PW_BITS_DEF,
    parameter int unsigned TO_BITS  = TO_BITS_DEF,
    parameter int unsigned FILT     = FILT_DEF,
    parameter int unsigned PW_MIN   = PW_MIN_DEF,
    parameter int unsigned PW_MAX   = PW_MAX_DEF,
    parameter int unsigned FAILSAFE = FAILSAFE_DEF
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        EN,
    input  logic [NCH-1:0]              RADIO_IN,
    output logic [NCH-1:0][PW_BITS-1:0] PULSE_WIDTH,
    output logic [NCH-1:0]              NEW_PULSE,
    output logic [NCH-1:0]              REJECT,
    output logic [NCH-1:0]              ONLINE,
    output logic                        ALL_ONLINE
);

    logic all_online_q, all_online_d;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        radio_rx_ch #(
            .PW_BITS  (PW_BITS),
            .TO_BITS  (TO_BITS),
            .FILT     (FILT),
            .PW_MIN   (PW_MIN),
            .PW_MAX   (PW_MAX),
            .FAILSAFE (FAILSAFE)
        ) u_ch (
            .clk_i         (CLK),
            .rst_i         (RESET),
            .en_i          (EN),
            .radio_i       (RADIO_IN[i]),
            .pulse_width_o (PULSE_WIDTH[i]),
            .new_pulse_o   (NEW_PULSE[i]),
            .reject_o      (REJECT[i]),
            .online_o      (ONLINE[i])
        );
    end

    always_comb begin
        all_online_d = &ONLINE;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            all_online_q <= 1'b0;
        end else begin
            all_online_q <= all_online_d;
        end
    end

    assign ALL_ONLINE = all_online_q;

endmodule
